// File: rtl/hdmi_capture_writer.sv
// Frame-aligned writer from the HDMI receiver 2-pixel stream into the framebuffer write FIFO.
// Latency: 1 cycle from accepted pixel_valid_i to fifo_wr_o; counters update 1 cycle after their event.
// No backpressure to the receiver: pairs arriving while the FIFO is full abort the frame until the next vsync.
// Optional input geometry measurement enabled by defining HDMI_CAPTURE_GEOMETRY_EN.
module hdmi_capture_writer #(
    parameter bit VSYNC_POL = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             link_up_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [47:0]      pixel_i,
    input  logic             pixel_valid_i,
    input  logic             fifo_full_i,
    output logic [48:0]      fifo_d_o,
    output logic             fifo_wr_o,
    output logic [CNT_W-1:0] frame_count_o,
    output logic [CNT_W-1:0] drop_count_o,
    output logic             overflow_o,
    output logic [11:0]      width_o,
    output logic [11:0]      height_o,
    output logic             geometry_valid_o
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ARMED,
        CAPTURE,
        DROP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic vsync_q;
    logic vs_edge;
    logic wr_d;
    logic sof_d;
    logic ovf_d;
    logic frame_inc;

    assign vs_edge = (vsync_i == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // vsync_q resets to the active level so a design coming out of reset mid-vsync sees no edge
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vsync_q <= VSYNC_POL;
            state_q <= IDLE;
        end else begin
            vsync_q <= vsync_i;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        sof_d     = 1'b0;
        ovf_d     = 1'b0;
        frame_inc = 1'b0;
        if (!link_up_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) state_d = SYNC;
                end
                SYNC: begin
                    if (!enable_i)    state_d = IDLE;
                    else if (vs_edge) state_d = ARMED;
                end
                ARMED: begin
                    // a pair coinciding with the vsync edge belongs to neither frame
                    if (vs_edge) begin
                        if (!enable_i) state_d = IDLE;
                    end else if (pixel_valid_i) begin
                        if (!fifo_full_i) begin
                            wr_d    = 1'b1;
                            sof_d   = 1'b1;
                            state_d = CAPTURE;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
                CAPTURE: begin
                    if (vs_edge) begin
                        frame_inc = 1'b1;
                        state_d   = enable_i ? ARMED : IDLE;
                    end else if (pixel_valid_i) begin
                        if (!fifo_full_i) begin
                            wr_d = 1'b1;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (vs_edge) state_d = enable_i ? ARMED : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fifo_d_o      <= '0;
            fifo_wr_o     <= 1'b0;
            overflow_o    <= 1'b0;
            frame_count_o <= '0;
            drop_count_o  <= '0;
        end else begin
            fifo_wr_o  <= wr_d;
            overflow_o <= ovf_d;
            if (wr_d)      fifo_d_o      <= {sof_d, pixel_i};
            if (frame_inc) frame_count_o <= frame_count_o + CNT_W'(1);
            if (ovf_d)     drop_count_o  <= drop_count_o + CNT_W'(1);
        end
    end

`ifdef HDMI_CAPTURE_GEOMETRY_EN
    logic        de_q;
    logic [11:0] pair_cnt;
    logic [11:0] line_w;
    logic [11:0] line_cnt;
    logic [12:0] pair_px;
    logic        counting;

    assign pair_px  = {pair_cnt, 1'b0};
    assign counting = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == DROP);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            de_q             <= 1'b0;
            pair_cnt         <= '0;
            line_w           <= '0;
            line_cnt         <= '0;
            width_o          <= '0;
            height_o         <= '0;
            geometry_valid_o <= 1'b0;
        end else begin
            de_q <= de_i;
            if (vs_edge) begin
                pair_cnt <= '0;
                line_cnt <= '0;
                // only a frame that was written out in full publishes its geometry
                if (state_q == CAPTURE && link_up_i) begin
                    width_o          <= line_w;
                    height_o         <= line_cnt;
                    geometry_valid_o <= 1'b1;
                end
            end else if (de_q && !de_i) begin
                line_w   <= pair_px[12] ? 12'hFFF : pair_px[11:0];
                line_cnt <= (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
                pair_cnt <= '0;
            end else if (de_i && pixel_valid_i && counting && pair_cnt != 12'hFFF) begin
                pair_cnt <= pair_cnt + 12'd1;
            end
            if (!link_up_i) geometry_valid_o <= 1'b0;
        end
    end
`else
    logic geom_unused;
    assign geom_unused      = de_i;
    assign width_o          = '0;
    assign height_o         = '0;
    assign geometry_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_capture_writer.sv
// Directed bench for hdmi_capture_writer: expected FIFO writes are queued as pairs are driven and checked as they emerge.
module tb_hdmi_capture_writer;

    localparam bit VP = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic        link_up_i;
    logic        vsync_i;
    logic        de_i;
    logic [47:0] pixel_i;
    logic        pixel_valid_i;
    logic        fifo_full_i;
    logic [48:0] fifo_d_o;
    logic        fifo_wr_o;
    logic [15:0] frame_count_o;
    logic [15:0] drop_count_o;
    logic        overflow_o;
    logic [11:0] width_o;
    logic [11:0] height_o;
    logic        geometry_valid_o;

    hdmi_capture_writer #(.VSYNC_POL(VP), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .enable_i         (enable_i),
        .link_up_i        (link_up_i),
        .vsync_i          (vsync_i),
        .de_i             (de_i),
        .pixel_i          (pixel_i),
        .pixel_valid_i    (pixel_valid_i),
        .fifo_full_i      (fifo_full_i),
        .fifo_d_o         (fifo_d_o),
        .fifo_wr_o        (fifo_wr_o),
        .frame_count_o    (frame_count_o),
        .drop_count_o     (drop_count_o),
        .overflow_o       (overflow_o),
        .width_o          (width_o),
        .height_o         (height_o),
        .geometry_valid_o (geometry_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [48:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   ovf_seen = 0;
    int   exp_ovf  = 0;
    int   fc_m     = 0;
    int   dc_m     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fifo_wr_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(fifo_wr_o), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_data", 64'(fifo_d_o), 64'(mon_e.d));
                chk("wr_latency_cycle", 64'(cyc), 64'(mon_e.c + 1));
            end
        end
        if (rst_n && overflow_o) ovf_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vsync_i = VP;
        step();
        step();
        vsync_i = !VP;
        step();
        step();
    endtask

    // evt: 0 none, 1 enable on, 2 enable off, 3 link drop (relock 3 pairs later)
    task automatic frame(input int lines, input int pairs, input bit cap_in,
                         input int full_at, input int evt, input int evt_at);
        bit   cap;
        int   k;
        exp_t e;
        cap = cap_in;
        k   = 0;
        vs_pulse();
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pairs; p++) begin
                if (k == evt_at) begin
                    case (evt)
                        1: enable_i = 1'b1;
                        2: enable_i = 1'b0;
                        3: begin link_up_i = 1'b0; cap = 1'b0; end
                        default: ;
                    endcase
                end
                if (evt == 3 && k == evt_at + 3) link_up_i = 1'b1;
                de_i          = 1'b1;
                pixel_valid_i = 1'b1;
                pixel_i       = {16'($urandom), 32'($urandom)};
                fifo_full_i   = (k == full_at);
                if (cap) begin
                    if (k == full_at) begin
                        cap = 1'b0;
                        exp_ovf++;
                        dc_m++;
                    end else begin
                        e.d = {1'(k == 0), pixel_i};
                        e.c = cyc;
                        sb.push_back(e);
                    end
                end
                k++;
                step();
            end
            de_i          = 1'b0;
            pixel_valid_i = 1'b0;
            fifo_full_i   = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        enable_i      = 1'b0;
        link_up_i     = 1'b0;
        vsync_i       = !VP;
        de_i          = 1'b0;
        pixel_i       = '0;
        pixel_valid_i = 1'b0;
        fifo_full_i   = 1'b0;
        repeat (3) step();
        chk("rst_fifo_d", 64'(fifo_d_o), 64'd0);
        chk("rst_fifo_wr", 64'(fifo_wr_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_frame_count", 64'(frame_count_o), 64'd0);
        chk("rst_drop_count", 64'(drop_count_o), 64'd0);
        chk("rst_width", 64'(width_o), 64'd0);
        chk("rst_height", 64'(height_o), 64'd0);
        chk("rst_geom_valid", 64'(geometry_valid_o), 64'd0);
        rst_n = 1'b1;
        step();

        // two clean 8x4-pair frames
        link_up_i = 1'b1;
        enable_i  = 1'b1;
        step();
        step();
        frame(4, 8, 1'b1, -1, 0, -1);
        frame(4, 8, 1'b1, -1, 0, -1);
        vs_pulse();
        fc_m = 2;
        chk("two_frames_fc", 64'(frame_count_o), 64'(fc_m));
        chk("two_frames_dc", 64'(drop_count_o), 64'(dc_m));
        chk("two_frames_drained", 64'(sb.size()), 64'd0);
`ifdef HDMI_CAPTURE_GEOMETRY_EN
        chk("geom_width", 64'(width_o), 64'd16);
        chk("geom_height", 64'(height_o), 64'd4);
        chk("geom_valid", 64'(geometry_valid_o), 64'd1);
`else
        chk("geom_width_tied", 64'(width_o), 64'd0);
        chk("geom_valid_tied", 64'(geometry_valid_o), 64'd0);
`endif

        // enable raised mid-frame: nothing until the following frame
        enable_i = 1'b0;
        vs_pulse();
        frame(4, 8, 1'b0, -1, 1, 10);
        chk("mid_enable_fc", 64'(frame_count_o), 64'(fc_m));
        frame(4, 8, 1'b1, -1, 0, -1);
        vs_pulse();
        fc_m++;
        chk("mid_enable_next_fc", 64'(frame_count_o), 64'(fc_m));

        // FIFO full on 5th pair aborts the frame
        frame(4, 8, 1'b1, 4, 0, -1);
        chk("ovf_dc", 64'(drop_count_o), 64'(dc_m));
        chk("ovf_pulses", 64'(ovf_seen), 64'(exp_ovf));
        frame(4, 8, 1'b1, -1, 0, -1);
        chk("ovf_aborted_not_counted", 64'(frame_count_o), 64'(fc_m));
        vs_pulse();
        fc_m++;
        chk("ovf_recover_fc", 64'(frame_count_o), 64'(fc_m));

        // link loss mid-frame, relock resumes only after a vsync edge
        frame(4, 8, 1'b1, -1, 3, 12);
        chk("link_drop_fc", 64'(frame_count_o), 64'(fc_m));
        chk("link_drop_drained", 64'(sb.size()), 64'd0);
        frame(4, 8, 1'b1, -1, 0, -1);
        vs_pulse();
        fc_m++;
        chk("relock_fc", 64'(frame_count_o), 64'(fc_m));

        // enable dropped mid-frame: the frame completes, then capture stops
        frame(4, 8, 1'b1, -1, 2, 10);
        vs_pulse();
        fc_m++;
        chk("disable_fc", 64'(frame_count_o), 64'(fc_m));
        frame(4, 8, 1'b0, -1, 0, -1);
        vs_pulse();
        chk("disabled_fc_hold", 64'(frame_count_o), 64'(fc_m));
        chk("final_dc", 64'(drop_count_o), 64'(dc_m));
        chk("final_ovf_pulses", 64'(ovf_seen), 64'(exp_ovf));
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
